// File: rtl/ifu_fetch.sv
// ifu_fetch: RV32 instruction fetch front end feeding the decode stage.
// Issues in-order word requests to instruction memory, buffers the in-order
// responses with their PC in a small FIFO, and hands them to decode over a
// valid/ready handshake. A redirect restarts fetch, flushes the buffer and
// discards responses that are still in flight.
// Optional feature: define IFU_EBREAK_HALT_EN to stop fetching after an
// ebreak (32'h0010_0073) has been buffered; a redirect resumes fetch.
module ifu_fetch #(
   parameter logic [31:0] RESET_PC = 32'h8000_0000,
   parameter int          DEPTH    = 2
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req_valid,
   output logic [31:0] imem_req_addr,
   input  logic        imem_req_ready,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        id_valid,
   output logic [31:0] id_instr,
   output logic [31:0] id_pc,
   input  logic        id_ready,
   output logic        halted
);

   localparam int            PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int            CW      = $clog2(DEPTH + 1);
   localparam logic [CW:0]   DEPTH_C = (CW+1)'(DEPTH);

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fq_ent_t;

   fq_ent_t          fq [DEPTH];
   logic [PW-1:0]    wr_ptr, rd_ptr;
   logic [CW-1:0]    fq_cnt, outstanding, drop_cnt;
   logic [31:0]      fetch_pc, rsp_pc;
   logic [CW:0]      used;
   logic             req_fire, rsp_drop, push, pop, halt_q;

   // Credit counts only registered state: a pop this cycle frees its slot
   // next cycle, which keeps the FIFO from ever overflowing.
   assign used           = {1'b0, outstanding} + {1'b0, fq_cnt};
   assign imem_req_valid = !rst && !redirect_valid && !halt_q && (used < DEPTH_C);
   assign imem_req_addr  = fetch_pc;
   assign req_fire       = imem_req_valid && imem_req_ready;

   // Responses that belong to a pre-redirect stream are dropped by count.
   assign rsp_drop = (drop_cnt != '0);
   assign push     = imem_rsp_valid && !rsp_drop && !redirect_valid;
   assign pop      = (fq_cnt != '0) && id_ready && !redirect_valid;

   assign id_valid = (fq_cnt != '0);
   assign id_instr = fq[rd_ptr].instr;
   assign id_pc    = fq[rd_ptr].pc;

   // Fetch and response PCs; both restart from the redirect target.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_pc <= RESET_PC;
         rsp_pc   <= RESET_PC;
      end else if (redirect_valid) begin
         fetch_pc <= redirect_pc;
         rsp_pc   <= redirect_pc;
      end else begin
         if (req_fire) fetch_pc <= fetch_pc + 32'd4;
         if (push)     rsp_pc   <= rsp_pc + 32'd4;
      end
   end

   // In-flight tracking; on redirect everything still outstanding after this
   // cycle's response becomes stale and is counted off as it returns.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         outstanding <= '0;
         drop_cnt    <= '0;
      end else begin
         outstanding <= outstanding + CW'(req_fire) - CW'(imem_rsp_valid);
         if (redirect_valid)
            drop_cnt <= outstanding - CW'(imem_rsp_valid);
         else if (imem_rsp_valid && rsp_drop)
            drop_cnt <= drop_cnt - CW'(1);
      end
   end

   // Instruction buffer: {pc,instr} FIFO, flushed on redirect.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         fq_cnt <= '0;
         for (int i = 0; i < DEPTH; i++) fq[i] <= '0;
      end else if (redirect_valid) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         fq_cnt <= '0;
      end else begin
         if (push) begin
            fq[wr_ptr] <= '{pc: rsp_pc, instr: imem_rsp_data};
            wr_ptr     <= wr_ptr + PW'(1);
         end
         if (pop) rd_ptr <= rd_ptr + PW'(1);
         fq_cnt <= fq_cnt + CW'(push) - CW'(pop);
      end
   end

`ifdef IFU_EBREAK_HALT_EN
   localparam logic [31:0] EBREAK = 32'h0010_0073;

   // Halt once an ebreak is buffered; redirect takes priority and resumes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         halt_q <= 1'b0;
      else if (redirect_valid)
         halt_q <= 1'b0;
      else if (push && (imem_rsp_data == EBREAK))
         halt_q <= 1'b1;
   end
`else
   assign halt_q = 1'b0;
`endif

   assign halted = halt_q;

endmodule

// File: tb/tb_ifu_fetch.sv
// Testbench for ifu_fetch: random memory/decode/redirect stimulus with an
// in-order memory model and a scoreboard of expected {pc,instr} deliveries.
module tb_ifu_fetch;
   localparam logic [31:0] RESET_PC = 32'h8000_0000;
   localparam int          DEPTH    = 2;
   localparam logic [31:0] EBREAK   = 32'h0010_0073;

   logic        clk = 1'b0, rst = 1'b1;
   logic        imem_req_valid, imem_req_ready = 1'b0;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid = 1'b0;
   logic [31:0] imem_rsp_data = '0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        id_valid, id_ready = 1'b0, halted;
   logic [31:0] id_instr, id_pc;

   always #5 clk = ~clk;

   ifu_fetch #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
      .imem_req_ready(imem_req_ready),
      .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc),
      .id_ready(id_ready), .halted(halted)
   );

   typedef struct {
      logic [31:0] addr;
      int          rdy;
      bit          stale;
   } mem_t;

   mem_t        mem_q[$];   // requests accepted by memory, not yet answered
   logic [31:0] sb_q[$];    // PCs expected at decode, in order
   int          checks = 0, errors = 0, pops = 0;
   int          cyc = 0, since = 0;
   logic [31:0] exp_fpc = RESET_PC;
   bit          halt_m = 1'b0;
   bit          rst_req = 1'b1, chk_lat = 1'b0, force_redir = 1'b0;
   logic [31:0] force_pc = '0;
   int          p_rdy = 100, p_idr = 100, p_redir = 0, lat_lo = 1, lat_hi = 1;

   // Instruction memory contents.
   function automatic logic [31:0] memfn(input logic [31:0] a);
`ifdef IFU_EBREAK_HALT_EN
      if (a == 32'h8000_0010 || a == 32'h8000_0108) return EBREAK;
`endif
      return a ^ 32'h5A5A_1234;
   endfunction

   function automatic logic [31:0] rand_pc();
      logic [31:0] r;
      r = $urandom;
      case ($urandom_range(3))
         0:       return RESET_PC + 32'($urandom_range(63)) * 32'd4;
         1:       return 32'hFFFF_FFF0 + 32'($urandom_range(3)) * 32'd4;
         2:       return {r[31:2], 2'b00};
         default: return RESET_PC;
      endcase
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%h exp=%h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // One clock: drive inputs at negedge, check outputs, advance the model.
   task automatic step();
      mem_t f;
      int   ns, nb;
      @(negedge clk);
      cyc++;
      rst = rst_req;
      if (rst) begin
         imem_req_ready = 1'b0; id_ready = 1'b0; redirect_valid = 1'b0;
         imem_rsp_valid = 1'b0; imem_rsp_data = '0;
         mem_q.delete(); sb_q.delete();
         exp_fpc = RESET_PC; halt_m = 1'b0;
      end else begin
         imem_req_ready = ($urandom_range(99) < p_rdy);
         id_ready       = ($urandom_range(99) < p_idr);
         redirect_valid = force_redir || (p_redir > 0 && $urandom_range(999) < p_redir);
         redirect_pc    = force_redir ? force_pc : rand_pc();
         if (mem_q.size() > 0 && mem_q[0].rdy <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = memfn(mem_q[0].addr);
         end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
         end
      end
      #1;
      if (rst) begin
         chk("rst_req_valid", imem_req_valid, 0);
         chk("rst_req_addr", imem_req_addr, RESET_PC);
         chk("rst_id_valid", id_valid, 0);
         chk("rst_id_instr", id_instr, 0);
         chk("rst_id_pc", id_pc, 0);
         chk("rst_halted", halted, 0);
      end else begin
         ns = 0;
         foreach (mem_q[i]) if (!mem_q[i].stale) ns++;
         nb = sb_q.size() - ns;   // entries sitting in the buffer
         chk("req_valid", imem_req_valid,
             !redirect_valid && !halt_m && (mem_q.size() + nb < DEPTH));
         if (imem_req_valid) chk("req_addr", imem_req_addr, exp_fpc);
         chk("id_valid", id_valid, nb != 0);
         chk("halted", halted, halt_m);
         if (chk_lat && since <= 2) chk("first_id_valid", id_valid, since == 2);
         if (imem_rsp_valid) begin
            f = mem_q.pop_front();
`ifdef IFU_EBREAK_HALT_EN
            if (!f.stale && !redirect_valid && memfn(f.addr) == EBREAK) halt_m = 1'b1;
`endif
         end
         if (imem_req_valid && imem_req_ready) begin
            mem_q.push_back('{addr: exp_fpc, rdy: cyc + $urandom_range(lat_hi, lat_lo), stale: 1'b0});
            sb_q.push_back(exp_fpc);
            exp_fpc = exp_fpc + 32'd4;
         end
         if (redirect_valid) begin
            foreach (mem_q[i]) mem_q[i].stale = 1'b1;
            sb_q.delete();
            exp_fpc = redirect_pc;
            halt_m  = 1'b0;
         end
         since++;
      end
   endtask

   task automatic do_reset();
      rst_req = 1'b1;
      repeat (3) step();
      rst_req = 1'b0;
      since = 0;
   endtask

   // Monitor: compares every decode handshake against the scoreboard and
   // checks the head is held while decode stalls.
   logic [31:0] hold_pc, hold_ins, mon_e;
   bit          hold_v = 1'b0;
   always @(negedge clk) begin
      #2;
      if (rst) begin
         hold_v = 1'b0;
      end else begin
         if (hold_v) begin
            chk("hold_pc", id_pc, hold_pc);
            chk("hold_instr", id_instr, hold_ins);
         end
         hold_v   = id_valid && !id_ready && !redirect_valid;
         hold_pc  = id_pc;
         hold_ins = id_instr;
         if (id_valid && id_ready && !redirect_valid) begin
            if (sb_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_pop id_pc=%h, scoreboard empty", id_pc);
            end else begin
               mon_e = sb_q.pop_front();
               chk("id_pc", id_pc, mon_e);
               chk("id_instr", id_instr, memfn(mon_e));
               pops++;
            end
         end
      end
   end

   initial begin
      // Reset release, 1-cycle memory, decode always ready.
      chk_lat = 1'b1;
      do_reset();
      repeat (5) step();
      chk_lat = 1'b0;
      // Redirect in a cycle that also has a response and a pop.
      force_redir = 1'b1; force_pc = 32'h8000_0100;
      step();
      force_redir = 1'b0;
      repeat (10) step();
      // Decode stall then release.
      p_idr = 0;   repeat (6) step();
      p_idr = 100; repeat (8) step();
      // Redirect with two requests in flight.
      lat_lo = 3; lat_hi = 3;
      do_reset();
      repeat (2) step();
      force_redir = 1'b1; force_pc = 32'h8000_0100;
      step();
      force_redir = 1'b0;
      repeat (12) step();
      // Toggling request ready, 3-cycle memory.
      p_rdy = 50; repeat (200) step();
      // Fully random traffic with redirects.
      p_rdy = 70; p_idr = 70; lat_lo = 1; lat_hi = 3; p_redir = 40;
      repeat (1500) step();
      // Address wrap across 2^32.
      force_redir = 1'b1; force_pc = 32'hFFFF_FFF8;
      step();
      force_redir = 1'b0;
      repeat (30) step();
      // Reset in the middle of traffic (memory reset along with it).
      do_reset();
      repeat (800) step();
      chk("enough_pops", pops > 200, 1);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
